// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-ROM fetch initiator with a prefetch queue and valid/ready output to decode
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   rom_addr / rom_data           fetch address (registered PC) and same-cycle ROM word
//   redirect_valid / redirect_pc  execute-stage PC change; flushes the queue
//   inst_valid / inst_data / inst_pc / inst_ready  head of the queue handed to decode
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2,
   parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   fetch_pc;
   logic [31:0]   pc_q   [QUEUE_DEPTH];
   logic [31:0]   data_q [QUEUE_DEPTH];
   logic [AW-1:0] head, tail;
   logic [CW-1:0] count;
   logic          pop, push, full;
   assign full       = count == CW'(QUEUE_DEPTH);
   assign inst_valid = count != '0;
   assign pop        = inst_valid & inst_ready;
   // a pop frees a slot in the same cycle, so a full queue still streams 1/cycle
   assign push       = !rst & !redirect_valid & (!full | pop);
   assign rom_addr   = fetch_pc;
   assign inst_data  = inst_valid ? data_q[head] : NOP_INST;
   assign inst_pc    = inst_valid ? pc_q[head] : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            tail     <= tail + AW'(1);
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop) head <= head + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // storage needs no reset: entries are only visible while count covers them
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[tail]   <= fetch_pc;
         data_q[tail] <= rom_data;
      end
   end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed + random checks of inst_fetch_unit against a queue-based reference model
module tb_inst_fetch_unit;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          DEPTH = 2;
   logic        clk = 1'b0;
   logic        rst, redirect_valid, inst_ready, inst_valid;
   logic [31:0] redirect_pc, rom_addr, rom_data, inst_data, inst_pc;
   logic        rst_w, valid_w;
   logic [31:0] addr_w, data_w, pc_w, rom_data_w;
   logic [31:0] mem [256];
   logic [63:0] mq [$];
   logic [31:0] mpc;
   int          n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   assign rom_data   = mem[rom_addr[9:2]];
   assign rom_data_w = mem[addr_w[9:2]];
   inst_fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready));
   inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(DEPTH), .NOP_INST(NOP)) dut_w (
      .clk(clk), .rst(rst_w), .rom_addr(addr_w), .rom_data(rom_data_w),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .inst_valid(valid_w), .inst_data(data_w), .inst_pc(pc_w), .inst_ready(1'b1));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // one clock: drive inputs, advance the reference model, compare all main outputs
   task automatic tick(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
      int  pre;
      logic p;
      rst = r; redirect_valid = rv; redirect_pc = rp; inst_ready = rdy;
      @(posedge clk);
      pre = mq.size();
      p   = pre > 0 && rdy;
      if (r) begin
         mq.delete(); mpc = 32'h0;
      end else if (rv) begin
         mq.delete(); mpc = {rp[31:2], 2'b00};
      end else begin
         if (p) void'(mq.pop_front());
         if (pre < DEPTH || p) begin
            mq.push_back({mpc, mem[mpc[9:2]]});
            mpc = mpc + 32'd4;
         end
      end
      @(negedge clk);
      chk("valid", 32'(inst_valid), 32'(mq.size() > 0));
      chk("pc", inst_pc, mq.size() > 0 ? mq[0][63:32] : 32'h0);
      chk("data", inst_data, mq.size() > 0 ? mq[0][31:0] : NOP);
      chk("rom_addr", rom_addr, mpc);
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h341CE137; mem[1] = 32'hF0C10113; mem[2] = 32'h00202023; mem[18] = 32'h00050283;
      mpc = 32'h0;
      rst_w = 1'b1;
      tick(1, 0, 0, 1); tick(1, 0, 0, 1);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_data", inst_data, NOP);
      chk("rst_addr", rom_addr, 32'h0);
      chk("w_rst_valid", 32'(valid_w), 32'h0);
      chk("w_rst_addr", addr_w, 32'hFFFF_FFF8);
      tick(0, 0, 0, 1);
      chk("t1_pc0", inst_pc, 32'h0);
      chk("t1_d0", inst_data, 32'h341CE137);
      tick(0, 0, 0, 1);
      chk("t1_d1", inst_data, 32'hF0C10113);
      tick(0, 0, 0, 1);
      chk("t1_pc2", inst_pc, 32'h8);
      chk("t1_d2", inst_data, 32'h00202023);
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
      chk("t2_freeze", rom_addr, 32'h8);
      chk("t2_head", inst_pc, 32'h0);
      tick(0, 0, 0, 1); chk("t2_seq4", inst_pc, 32'h4);
      tick(0, 0, 0, 1); chk("t2_seq8", inst_pc, 32'h8);
      tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      tick(0, 1, 32'h48, 0);
      chk("t3_gap", 32'(inst_valid), 32'h0);
      tick(0, 0, 0, 1);
      chk("t3_pc", inst_pc, 32'h48);
      chk("t3_data", inst_data, 32'h00050283);
      tick(0, 1, 32'h4E, 1);
      chk("t4_align", rom_addr, 32'h4C);
      tick(0, 1, 32'h64, 1); tick(0, 1, 32'h94, 1); tick(0, 0, 0, 1);
      chk("t4_last", inst_pc, 32'h94);
      for (int i = 0; i < 300; i++)
         tick($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) < 7);
      tick(0, 0, 0, 1); tick(0, 0, 0, 1);
      tick(1, 1, 32'h48, 1);
      chk("t6_valid", 32'(inst_valid), 32'h0);
      chk("t6_addr", rom_addr, 32'h0);
      rst_w = 1'b0;
      tick(0, 0, 0, 1);
      chk("t5_pc0", pc_w, 32'hFFFF_FFF8);
      chk("t5_d0", data_w, mem[8'hFE]);
      tick(0, 0, 0, 1);
      chk("t5_pc1", pc_w, 32'hFFFF_FFFC);
      tick(0, 0, 0, 1);
      chk("t5_pc2", pc_w, 32'h0);
      chk("t5_valid", 32'(valid_w), 32'h1);
      chk("t5_addr", addr_w, 32'h4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
